// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code up/down counter slice.
//   - cnt_mode_e : counting behaviour at the range boundaries
//   - bin2gray() : binary to Gray conversion
//   - gray2bin() : Gray to binary conversion (prefix XOR from the MSB)
// Both helpers work on a fixed GW-bit container. Callers zero-extend their
// operand and truncate the result. Zero upper bits stay zero through either
// conversion, so this is exact for any WIDTH <= GW.
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GW = 32;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] bin_i);
    return bin_i ^ (bin_i >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] gray_i);
    logic [GW-1:0] bin_s;
    bin_s[GW-1] = gray_i[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      bin_s[i] = bin_s[i+1] ^ gray_i[i];
    end
    return bin_s;
  endfunction

endpackage

// File: rtl/gray2bin_decode.sv
// -----------------------------------------------------------------------------
// gray2bin_decode
// Combinational Gray-to-binary decoder.
// Ports:
//   gray_i  in  WIDTH  Gray-coded value
//   bin_o   out WIDTH  equivalent binary value
// -----------------------------------------------------------------------------
module gray2bin_decode
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Prefix-XOR decode through the shared helper
  always_comb begin
    bin_o = WIDTH'(gray2bin(GW'(gray_i)));
  end

endmodule

// File: rtl/gray_updown_counter_chk.sv
// -----------------------------------------------------------------------------
// gray_updown_counter_chk
// Assertion-only companion of gray_updown_counter. It decodes the Gray view
// independently and checks that it always agrees with the binary view. In
// saturate mode it also checks that the wrap pulse never fires.
// Ports:
//   clk      in  1      counter clock
//   rst      in  1      counter reset; checks are disabled while it is high
//   gray_i   in  WIDTH  registered Gray view
//   bin_i    in  WIDTH  registered binary view
//   wrap_i   in  1      registered wrap pulse
// -----------------------------------------------------------------------------
module gray_updown_counter_chk #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] gray_i,
  input logic [WIDTH-1:0] bin_i,
  input logic             wrap_i
);

  logic [WIDTH-1:0] dec_s;

  gray2bin_decode #(.WIDTH(WIDTH)) u_decode (
    .gray_i (gray_i),
    .bin_o  (dec_s)
  );

  a_bin_matches_gray: assert property (@(posedge clk) disable iff (rst) bin_i == dec_s);

  a_no_wrap_when_sat: assert property (@(posedge clk) disable iff (rst)
                                       (SATURATE != 0) |-> !wrap_i);

endmodule

// File: rtl/gray_updown_counter.sv
// -----------------------------------------------------------------------------
// gray_updown_counter
// Up/down counter whose state is held in Gray code. The counter also keeps a
// registered binary copy of the count. It supports a synchronous load and can
// either wrap or saturate at the range boundaries.
// Ports:
//   clk       in   1      clock; all state updates on the rising edge
//   rst       in   1      synchronous active-high reset
//   en        in   1      count enable (one step per cycle)
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      synchronous load strobe (overrides en)
//   load_val  in   WIDTH  binary value to load
//   gray_out  out  WIDTH  registered Gray code of the count
//   bin_out   out  WIDTH  registered binary count
//   wrap      out  1      registered one-cycle pulse after a wrap step
//   at_max    out  1      bin_out is all ones
//   at_min    out  1      bin_out is zero
// -----------------------------------------------------------------------------
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam cnt_mode_e        MODE_C = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Next-state selection: load > en > hold. The step is taken from the
  // registered binary copy, so the feedback path has no Gray decode chain.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_C) begin
          if (MODE_C == CNT_SAT) begin
            bin_d = bin_q;
          end else begin
            bin_d  = ZERO_C;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + ONE_C;
        end
      end else begin
        if (bin_q == ZERO_C) begin
          if (MODE_C == CNT_SAT) begin
            bin_d = bin_q;
          end else begin
            bin_d  = MAX_C;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - ONE_C;
        end
      end
    end else begin
      bin_d = bin_q;
    end
    // The Gray view is re-encoded from the next binary value.
    gray_d = WIDTH'(bin2gray(GW'(bin_d)));
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= ZERO_C;
      gray_q <= ZERO_C;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray_out = gray_q;
  assign bin_out  = bin_q;
  assign wrap     = wrap_q;
  assign at_max   = (bin_q == MAX_C);
  assign at_min   = (bin_q == ZERO_C);

  gray_updown_counter_chk #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .gray_i (gray_q),
    .bin_i  (bin_q),
    .wrap_i (wrap_q)
  );

endmodule
